// File: rtl/p_hit_pkg.sv
// p_hit_pkg: shared fixed-point types and limits for the hit-point stage
package p_hit_pkg;
  localparam int Q_BITS_DEF = 16;
  typedef logic signed [31:0] fx_t;
  typedef fx_t vec3_t [2:0];
  localparam fx_t FX_MAX = 32'sh7FFF_FFFF;
  localparam fx_t FX_MIN = 32'sh8000_0000;
endpackage

// File: rtl/fifo_array.sv
// fifo_array: first-word-fall-through FIFO of ARRAY_SIZE-word entries; occupancy is tracked by the caller
module fifo_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int ARRAY_SIZE = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [ARRAY_SIZE*WIDTH-1:0] din,
  output logic [ARRAY_SIZE*WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [ARRAY_SIZE*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + AW'(wr_en);
      rp <= rp + AW'(rd_en);
    end
  always_ff @(posedge clock)
    if (wr_en) mem[wp] <= din;
  assign dout = mem[rp];
endmodule

// File: rtl/p_hit_point_lane.sv
// p_hit_point_lane: one axis of P = origin + t*dir; P_HIT_SAT_EN selects saturating instead of wrapping arithmetic
module p_hit_point_lane
  import p_hit_pkg::*;
#(
  parameter int Q_BITS = Q_BITS_DEF
) (
  input  logic clock,
  input  logic reset,
  input  fx_t  t,
  input  fx_t  d,
  input  fx_t  o,
  output fx_t  sum
);
  logic signed [63:0] prod, sh;
  fx_t o1, nxt;
  assign sh = prod >>> Q_BITS;
`ifdef P_HIT_SAT_EN
  fx_t shc;
  logic signed [32:0] s33;
  always_comb begin
    shc = sh > 64'(FX_MAX) ? FX_MAX : sh < 64'(FX_MIN) ? FX_MIN : fx_t'(sh);
    s33 = 33'(o1) + 33'(shc);
    nxt = s33 > 33'(FX_MAX) ? FX_MAX : s33 < 33'(FX_MIN) ? FX_MIN : fx_t'(s33);
  end
`else
  assign nxt = o1 + fx_t'(sh);
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prod <= '0;
      o1   <= '0;
      sum  <= '0;
    end else begin
      prod <= 64'(t) * 64'(d);
      o1   <= o;
      sum  <= nxt;
    end
endmodule

// File: rtl/p_hit_point.sv
// p_hit_point: pairs p_hit_1 t values with buffered rays and emits P = origin + t*dir through a FWFT FIFO
// P_HIT_SAT_EN enables saturating lane arithmetic.
module p_hit_point
  import p_hit_pkg::*;
#(
  parameter int Q_BITS    = Q_BITS_DEF,
  parameter int RAY_DEPTH = 1024,
  parameter int OUT_DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  fx_t   t_in,
  input  logic  t_empty,
  output logic  t_rd_en,
  input  vec3_t origin,
  input  vec3_t dir,
  input  logic  ray_wr_en,
  output logic  ray_full,
  output vec3_t p_out,
  output logic  hit_out,
  output logic  out_empty,
  input  logic  out_rd_en
);
  localparam int RW = $clog2(RAY_DEPTH) + 1;
  localparam int OW = $clog2(OUT_DEPTH) + 1;
  logic [RW-1:0] ray_cnt;
  logic [OW-1:0] out_cnt;
  logic v1, v2, h1, h2, fire, ray_push, out_pop;
  logic [95:0] o_head, d_head;
  logic [96:0] out_head;
  vec3_t sum;
  assign ray_full  = ray_cnt == RW'(RAY_DEPTH);
  assign out_empty = out_cnt == '0;
  assign ray_push  = ray_wr_en && !ray_full;
  assign out_pop   = out_rd_en && !out_empty;
  // Credit check counts in-flight results so the output FIFO can never overflow.
  assign fire      = !t_empty && ray_cnt != '0 && (OW'(v1) + OW'(v2) + out_cnt) < OW'(OUT_DEPTH);
  assign t_rd_en   = fire;
  assign hit_out   = !out_empty && out_head[96];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ray_cnt <= '0;
      out_cnt <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      h1      <= 1'b0;
      h2      <= 1'b0;
    end else begin
      ray_cnt <= ray_cnt + RW'(ray_push) - RW'(fire);
      out_cnt <= out_cnt + OW'(v2) - OW'(out_pop);
      v1      <= fire;
      v2      <= v1;
      h1      <= t_in > 0;
      h2      <= h1;
    end
  fifo_array #(.WIDTH(32), .DEPTH(RAY_DEPTH), .ARRAY_SIZE(3)) u_origin (
    .clock(clock), .reset(reset), .wr_en(ray_push), .rd_en(fire),
    .din({origin[2], origin[1], origin[0]}), .dout(o_head)
  );
  fifo_array #(.WIDTH(32), .DEPTH(RAY_DEPTH), .ARRAY_SIZE(3)) u_dir (
    .clock(clock), .reset(reset), .wr_en(ray_push), .rd_en(fire),
    .din({dir[2], dir[1], dir[0]}), .dout(d_head)
  );
  fifo_array #(.WIDTH(97), .DEPTH(OUT_DEPTH), .ARRAY_SIZE(1)) u_out (
    .clock(clock), .reset(reset), .wr_en(v2), .rd_en(out_pop),
    .din({h2, sum[2], sum[1], sum[0]}), .dout(out_head)
  );
  for (genvar i = 0; i < 3; i++) begin : g_lane
    p_hit_point_lane #(.Q_BITS(Q_BITS)) u_lane (
      .clock(clock), .reset(reset), .t(t_in),
      .d(d_head[32*i +: 32]), .o(o_head[32*i +: 32]), .sum(sum[i])
    );
    assign p_out[i] = out_empty ? '0 : out_head[32*i +: 32];
  end
endmodule

// File: tb/tb_p_hit_point.sv
// tb_p_hit_point: directed scoreboard bench for p_hit_point
module tb_p_hit_point;
  import p_hit_pkg::*;
  localparam int RD = 1024;
  localparam longint LMAX = 64'sh7FFFFFFF;
  localparam longint LMIN = -64'sh80000000;
  typedef struct { fx_t p0, p1, p2; logic hit; } exp_t;
  typedef struct { fx_t o0, o1, o2, d0, d1, d2; } ray_t;
  logic clock = 0, reset = 0;
  fx_t t_in;
  logic t_empty, t_rd_en, ray_full, hit_out, out_empty;
  logic ray_wr_en = 0, out_rd_en = 0;
  vec3_t origin, dir, p_out;
  fx_t tmem [4096];
  int tw = 0, tr = 0, cyc = 0;
  int n_cmp = 0, n_err = 0, t_pushed = 0, rays_acc = 0;
  exp_t exp_q[$];
  ray_t ray_q[$];

  p_hit_point dut (
    .clock(clock), .reset(reset), .t_in(t_in), .t_empty(t_empty), .t_rd_en(t_rd_en),
    .origin(origin), .dir(dir), .ray_wr_en(ray_wr_en), .ray_full(ray_full),
    .p_out(p_out), .hit_out(hit_out), .out_empty(out_empty), .out_rd_en(out_rd_en)
  );

  always #5 clock = ~clock;
  // Upstream FWFT t FIFO model
  assign t_empty = tw == tr;
  assign t_in = tmem[tr % 4096];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (t_rd_en) tr <= tr + 1;
  end

  function automatic fx_t lane(fx_t o, fx_t d, fx_t t);
    longint p = longint'(t) * longint'(d);
    longint sh = p >>> 16;
`ifdef P_HIT_SAT_EN
    longint s;
    if (sh > LMAX) sh = LMAX;
    else if (sh < LMIN) sh = LMIN;
    s = longint'(o) + sh;
    if (s > LMAX) s = LMAX;
    else if (s < LMIN) s = LMIN;
    return fx_t'(s);
`else
    return o + fx_t'(sh);
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got 0x%h, expected 0x%h", tag, obs, expv);
    end
  endtask

  task automatic push_ray(fx_t o0, fx_t o1, fx_t o2, fx_t d0, fx_t d1, fx_t d2);
    ray_t r;
    @(negedge clock);
    origin[0] = o0; origin[1] = o1; origin[2] = o2;
    dir[0] = d0; dir[1] = d1; dir[2] = d2;
    ray_wr_en = 1;
    if (rays_acc - t_pushed < RD) begin
      r = '{o0, o1, o2, d0, d1, d2};
      ray_q.push_back(r);
      rays_acc++;
    end
    @(posedge clock);
    #1 ray_wr_en = 0;
  endtask

  task automatic push_t(fx_t t);
    ray_t r;
    exp_t e;
    r = ray_q.pop_front();
    e = '{lane(r.o0, r.d0, t), lane(r.o1, r.d1, t), lane(r.o2, r.d2, t), t > 0};
    exp_q.push_back(e);
    tmem[tw % 4096] = t;
    tw++;
    t_pushed++;
  endtask

  task automatic drain(int n, string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int w;
      w = 0;
      @(negedge clock);
      while (out_empty && w < 100) begin
        @(negedge clock);
        w++;
      end
      if (out_empty) begin
        check({tag, "_timeout_out_empty"}, 32'(out_empty), 32'd0);
        return;
      end
      e = exp_q.pop_front();
      check({tag, "_px"}, p_out[0], e.p0);
      check({tag, "_py"}, p_out[1], e.p1);
      check({tag, "_pz"}, p_out[2], e.p2);
      check({tag, "_hit"}, 32'(hit_out), 32'(e.hit));
      out_rd_en = 1;
      @(posedge clock);
      #1 out_rd_en = 0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, w, c0;
    origin = '{default: 0};
    dir = '{default: 0};
    #12;
    check("rst_t_rd_en", 32'(t_rd_en), 32'd0);
    check("rst_ray_full", 32'(ray_full), 32'd0);
    check("rst_out_empty", 32'(out_empty), 32'd1);
    check("rst_p_out", p_out[0] | p_out[1] | p_out[2], 32'd0);
    check("rst_hit_out", 32'(hit_out), 32'd0);
    @(negedge clock) reset = 1;

    // Basic point and issue-to-output latency
    push_ray(32'h10000, 32'h20000, 32'h30000, 32'h10000, 32'h0, 32'hFFFF0000);
    push_t(32'h20000);
    w = 0;
    @(negedge clock);
    while (!t_rd_en && w < 20) begin @(negedge clock); w++; end
    check("t1_fire", 32'(t_rd_en), 32'd1);
    c0 = cyc;
    w = 0;
    do begin @(negedge clock); w++; end while (out_empty && w < 20);
    check("t1_latency", 32'(cyc - c0), 32'd3);
    check("t1_px_const", p_out[0], 32'h30000);
    check("t1_pz_const", p_out[2], 32'h10000);
    drain(1, "t1");

    // Negative t
    push_ray(32'h10000, 32'h20000, 32'h30000, 32'h10000, 32'h0, 32'hFFFF0000);
    push_t(32'hFFFF0000);
    drain(1, "t2");

    // Backpressure: credit allows only OUT_DEPTH issues
    for (int i = 0; i < 6; i++)
      push_ray(fx_t'(i << 16), fx_t'(-i), fx_t'(3 * i), 32'h10000, fx_t'(i * 7), 32'hFFFE0000);
    for (int i = 0; i < 6; i++) push_t(fx_t'(32'h8000 + i * 32'h11111));
    pulses = 0;
    repeat (12) begin
      @(negedge clock);
      if (t_rd_en) pulses++;
    end
    check("t3_pulses", 32'(pulses), 32'd4);
    check("t3_out_empty", 32'(out_empty), 32'd0);
    check("t3_t_empty", 32'(t_empty), 32'd0);
    drain(1, "t3a");
    @(negedge clock);
    check("t3_reissue", 32'(t_rd_en), 32'd1);
    drain(5, "t3b");

    // Saturation / wrap corners
    push_ray(32'h0, 32'h0, 32'h7FFF0000, 32'h7FFF0000, 32'h80000000, 32'h10000);
    push_t(32'h7FFF0000);
    drain(1, "t4");

    // Ray buffer full, extra write dropped, FIFO pairing order
    for (int i = 0; i < RD; i++)
      push_ray(fx_t'(i << 16), fx_t'(-i), fx_t'(i * 3), 32'h10000, fx_t'(i), 32'h20000);
    @(negedge clock);
    check("t5_full", 32'(ray_full), 32'd1);
    push_ray(32'h12345, 32'h12345, 32'h12345, 32'h12345, 32'h12345, 32'h12345);
    check("t5_full_after_extra", 32'(ray_full), 32'd1);
    for (int i = 0; i < RD; i++) push_t(fx_t'(32'h10000 + i));
    drain(RD, "t5");
    check("t5_not_full", 32'(ray_full), 32'd0);

    // Reset with two in flight and two queued in the output FIFO
    for (int i = 0; i < 4; i++)
      push_ray(fx_t'(32'h50000 + i), 32'h0, 32'h0, 32'h10000, 32'h10000, 32'h10000);
    for (int i = 0; i < 4; i++) push_t(fx_t'(32'h10000 * (i + 1)));
    pulses = 0;
    w = 0;
    while (pulses < 4 && w < 30) begin
      @(negedge clock);
      if (t_rd_en) pulses++;
      w++;
    end
    check("t6_pulses", 32'(pulses), 32'd4);
    @(posedge clock);
    #1 reset = 0;
    #1;
    check("t6_out_empty", 32'(out_empty), 32'd1);
    check("t6_t_rd_en", 32'(t_rd_en), 32'd0);
    check("t6_ray_full", 32'(ray_full), 32'd0);
    check("t6_hit_out", 32'(hit_out), 32'd0);
    check("t6_p_out", p_out[0] | p_out[1] | p_out[2], 32'd0);
    exp_q.delete();
    ray_q.delete();
    repeat (2) @(negedge clock);
    reset = 1;
    push_ray(32'h40000, 32'hFFFF0000, 32'h8000, 32'h20000, 32'h10000, 32'hFFFF8000);
    push_t(32'h18000);
    drain(1, "t6");
    repeat (5) @(negedge clock);
    check("end_out_empty", 32'(out_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
